// File: rtl/regfile_writeback.sv
// Register file write-side controller: merges ALU results and buffered load
// returns onto the single write port and tracks outstanding-load busy bits.
module regfile_writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ok,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] WriteData,
  output logic              err_waw
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ld_entry_t;

  ld_entry_t         fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_ld_q, wb_ld_d;
  logic              err_q, err_d;

  logic      alu_wr;
  logic      fifo_full;
  logic      push;
  logic      pop;
  ld_entry_t head;

  // Handshake and arbitration; ALU always wins, loads drain in idle slots
  always_comb begin
    fifo_full = (count_q == CNT_W'(DEPTH));
    alu_wr    = alu_valid && (alu_rd != '0);
    push      = ld_valid && !fifo_full;
    pop       = (count_q != '0) && !alu_wr;
    head      = fifo_q[rd_ptr_q];
  end

  // Decode-facing status; forced to idle values while reset is asserted
  always_comb begin
    ld_ready = rst || !fifo_full;
    issue_ok = rst || !busy_q[issue_rd];
    rs1_busy = !rst && busy_q[rs1];
    rs2_busy = !rst && busy_q[rs2];
  end

  // Next-state: FIFO bookkeeping, write-port selection, scoreboard, WAW flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    busy_d     = busy_q;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    wb_ld_d    = 1'b0;
    err_d      = err_q;

    if (push) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
    if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
    if (push && !pop)      count_d = CNT_W'(count_q + CNT_W'(1));
    else if (!push && pop) count_d = CNT_W'(count_q - CNT_W'(1));

    if (alu_wr) begin
      regwrite_d = 1'b1;
      rd_d       = alu_rd;
      wdata_d    = alu_data;
    end else if (pop && (head.rd != '0)) begin
      regwrite_d = 1'b1;
      rd_d       = head.rd;
      wdata_d    = head.data;
      wb_ld_d    = 1'b1;
    end

    // Clear retires with the register-file capture; a same-cycle set wins
    if (regwrite_q && wb_ld_q) busy_d[rd_q] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    if (alu_wr && busy_q[alu_rd]) err_d = 1'b1;
  end

  // Control and output state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      wb_ld_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      wb_ld_q    <= wb_ld_d;
      err_q      <= err_d;
    end
  end

  // Load-return storage; contents are don't-care once the pointers reset
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_q[wr_ptr_q] <= '{rd: ld_rd, data: ld_data};
  end

  assign RegWrite  = regwrite_q;
  assign rd        = rd_q;
  assign WriteData = wdata_q;
  assign err_waw   = err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic against
// a queue-based reference model.
module tb_regfile_writeback;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ok;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] WriteData;
  logic              err_waw;

  always #5 clk = ~clk;

  regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(issue_ok),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData), .err_waw(err_waw)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: write port contents, busy set, and load queue
  bit                m_we      = 1'b0;
  logic [ADDR_W-1:0] m_rd      = '0;
  logic [DATA_W-1:0] m_wd      = '0;
  bit                m_from_ld = 1'b0;
  bit                m_err     = 1'b0;
  bit                m_busy [32];
  logic [ADDR_W+DATA_W-1:0] m_q [$];

  task automatic idle();
    rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  // One clock: check status outputs, advance model, check write port after the edge
  task automatic cycle();
    bit rdy;
    bit alu_w;
    logic [ADDR_W+DATA_W-1:0] e;
    @(negedge clk);
    check_eq("ld_ready", 32'(ld_ready), 32'(rst || (m_q.size() != DEPTH)));
    check_eq("issue_ok", 32'(issue_ok), 32'(rst || !m_busy[issue_rd]));
    check_eq("rs1_busy", 32'(rs1_busy), 32'(!rst && m_busy[rs1]));
    check_eq("rs2_busy", 32'(rs2_busy), 32'(!rst && m_busy[rs2]));
    if (rst) begin
      m_we = 1'b0; m_rd = '0; m_wd = '0; m_from_ld = 1'b0; m_err = 1'b0;
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      rdy   = (m_q.size() != DEPTH);
      alu_w = alu_valid && (alu_rd != 0);
      if (alu_w && m_busy[alu_rd]) m_err = 1'b1;
      if (m_we && m_from_ld) m_busy[m_rd] = 1'b0;
      if (issue_valid && (issue_rd != 0)) m_busy[issue_rd] = 1'b1;
      if (alu_w) begin
        m_we = 1'b1; m_rd = alu_rd; m_wd = alu_data; m_from_ld = 1'b0;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (e[ADDR_W+DATA_W-1:DATA_W] != 0) begin
          m_we = 1'b1; m_rd = e[ADDR_W+DATA_W-1:DATA_W]; m_wd = e[DATA_W-1:0]; m_from_ld = 1'b1;
        end else begin
          m_we = 1'b0; m_from_ld = 1'b0;
        end
      end else begin
        m_we = 1'b0; m_from_ld = 1'b0;
      end
      if (ld_valid && rdy) m_q.push_back({ld_rd, ld_data});
    end
    @(posedge clk);
    #1;
    check_eq("RegWrite",  32'(RegWrite),  32'(m_we));
    check_eq("rd",        32'(rd),        32'(m_rd));
    check_eq("WriteData", WriteData,      m_wd);
    check_eq("err_waw",   32'(err_waw),   32'(m_err));
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    idle();

    // Initial reset
    rst = 1'b1; cycle(); cycle();
    idle();
    check_eq("rst_we", 32'(RegWrite), 32'd0);
    check_eq("rst_wd", WriteData, 32'd0);

    // ALU write and x0 suppression
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF; cycle();
    check_eq("alu_we", 32'(RegWrite), 32'd1);
    check_eq("alu_rd", 32'(rd), 32'd3);
    check_eq("alu_wd", WriteData, 32'hDEADBEEF);
    alu_rd = 5'd0; alu_data = 32'h55; cycle();
    check_eq("alu_x0_we", 32'(RegWrite), 32'd0);
    check_eq("alu_x0_hold", WriteData, 32'hDEADBEEF);

    // Load latency and scoreboard
    idle(); issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; cycle();
    check_eq("sb_set", 32'(rs1_busy), 32'd1);
    idle(); rs1 = 5'd7; cycle();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234; cycle();
    idle(); rs1 = 5'd7; cycle();
    check_eq("ld_we", 32'(RegWrite), 32'd1);
    check_eq("ld_rd", 32'(rd), 32'd7);
    check_eq("ld_wd", WriteData, 32'h1234);
    check_eq("sb_hold", 32'(rs1_busy), 32'd1);
    cycle();
    check_eq("sb_clr", 32'(rs1_busy), 32'd0);
    check_eq("ld_we_off", 32'(RegWrite), 32'd0);

    // Priority and full: ALU stream while loads fill the FIFO
    for (int i = 0; i < 5; i++) begin
      idle(); alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'(i);
      ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'hA0 + 32'(i);
      cycle();
      if (i == 3) check_eq("full_ready", 32'(ld_ready), 32'd0);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("drain_rd", 32'(rd), 32'(10 + i));
      check_eq("drain_wd", WriteData, 32'hA0 + 32'(i));
      if (i == 0) check_eq("ready_after_pop", 32'(ld_ready), 32'd1);
    end
    cycle();
    check_eq("drain_empty", 32'(RegWrite), 32'd0);

    // Push and pop together at count 2
    for (int i = 0; i < 2; i++) begin
      idle(); alu_valid = 1'b1; alu_rd = 5'd1; ld_valid = 1'b1;
      ld_rd = 5'(20 + i); ld_data = 32'hB0 + 32'(i); cycle();
    end
    idle(); ld_valid = 1'b1; ld_rd = 5'd22; ld_data = 32'hB2; cycle();
    check_eq("pp_rd", 32'(rd), 32'd20);
    idle(); cycle(); cycle();
    check_eq("pp_last", 32'(rd), 32'd22);
    cycle();

    // Issue to x9 in the cycle its load write is on the port
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; cycle();
    idle(); ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99; cycle();
    idle(); cycle();
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9; cycle();
    check_eq("set_beats_clr", 32'(rs1_busy), 32'd1);
    idle(); ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h98; cycle();
    idle(); rs1 = 5'd9; cycle(); cycle();
    check_eq("x9_clr", 32'(rs1_busy), 32'd0);

    // WAW on a busy register
    idle(); issue_valid = 1'b1; issue_rd = 5'd4; cycle();
    idle(); alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44; cycle();
    check_eq("waw_we", 32'(RegWrite), 32'd1);
    check_eq("waw_err", 32'(err_waw), 32'd1);
    idle(); cycle(); cycle(); cycle();
    check_eq("waw_sticky", 32'(err_waw), 32'd1);

    // Reset mid-stream with queued loads and busy x5
    idle(); issue_valid = 1'b1; issue_rd = 5'd5; cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); alu_valid = 1'b1; alu_rd = 5'd2; ld_valid = 1'b1;
      ld_rd = 5'd5; ld_data = 32'hC0 + 32'(i); cycle();
    end
    idle(); rst = 1'b1; rs1 = 5'd5; cycle();
    check_eq("mrst_we", 32'(RegWrite), 32'd0);
    check_eq("mrst_ready", 32'(ld_ready), 32'd1);
    check_eq("mrst_busy", 32'(rs1_busy), 32'd0);
    check_eq("mrst_err", 32'(err_waw), 32'd0);
    idle(); rs1 = 5'd5;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("mrst_nowrite", 32'(RegWrite), 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [ADDR_W-1:0] ird;
      idle();
      rst       = ($urandom % 128) == 0;
      alu_valid = ($urandom % 3) == 0;
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom % 2) == 0;
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      ird       = 5'($urandom_range(0, 7));
      issue_rd  = ird;
      issue_valid = (($urandom % 3) == 0) && !m_busy[ird];
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side controller for the 32x32 integer register file: merges ALU results and late-returning load data onto the single write port (RegWrite/rd/WriteData).
- Buffers load returns in a small FIFO and gives ALU results priority.
- Keeps a per-register busy scoreboard so decode can stall on outstanding loads.
- Sits between execute/memory stages and the register file write port.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width (32 registers).
- DEPTH, 4, load-return FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU result present this cycle (always accepted).
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load return valid.
- ld_ready  out  1  FIFO can accept a load return.
- ld_rd  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load data.
- issue_valid  in  1  a load is being issued this cycle.
- issue_rd  in  ADDR_W  destination of the issued load.
- issue_ok  out  1  issue_rd is not busy (issuer must not issue when low).
- rs1  in  ADDR_W  decode source 1 query.
- rs2  in  ADDR_W  decode source 2 query.
- rs1_busy  out  1  rs1 has an outstanding load.
- rs2_busy  out  1  rs2 has an outstanding load.
- RegWrite  out  1  register file write enable.
- rd  out  ADDR_W  register file write index.
- WriteData  out  DATA_W  register file write data.
- err_waw  out  1  sticky: ALU wrote a busy register.

Behaviour:
- Reset (rst high at a rising edge): RegWrite=0, rd=0, WriteData=0, FIFO emptied (pointers and count 0), busy vector all 0, err_waw=0. Applies mid-operation; in-flight entries are discarded. Outputs during reset: ld_ready=1, issue_ok=1, rs*_busy=0.
- ALU path: alu_valid && alu_rd!=0 in cycle c → RegWrite=1, rd=alu_rd, WriteData=alu_data during c+1 (registered). alu_rd==0 produces no write (RegWrite=0).
- Load path: ld_valid && ld_ready in cycle c → entry pushed at end of c.
- Pop rule: pop occurs when FIFO non-empty and no ALU write is requested (alu_valid && alu_rd!=0 is false) in that cycle. An entry pushed in c is poppable in c+1 at earliest, giving RegWrite during c+2. No fall-through.
- A popped entry with rd==0 is consumed with RegWrite=0.
- When there is no winning source, RegWrite=0; rd and WriteData hold their last values.
- ld_ready = (count != DEPTH), combinational from registered count. Push and pop in the same cycle leave count unchanged.
- When full, ld_ready=0 even if a pop happens that cycle.
- Pointers wrap modulo DEPTH.
- Scoreboard, set: issue_valid && issue_rd!=0 sets busy[issue_rd] at end of cycle.
- Scoreboard, clear: busy[r] clears at the end of the cycle in which a load-sourced write to r is on RegWrite/rd, i.e. the same edge at which the register file captures the data. A set and a clear to the same register in the same cycle leave it set.
- busy[0] is always 0.
- rs1_busy=busy[rs1], rs2_busy=busy[rs2], issue_ok=!busy[issue_rd]; all combinational from registered state.
- issue_valid while busy[issue_rd]=1 is a protocol violation (bench asserts). Busy stays 1.
- WAW: an ALU write accepted to a busy register still writes and sets err_waw=1. err_waw clears only on reset.
- Starvation: a continuous ALU stream blocks FIFO drain. Upstream throttling is via ld_ready only.

Test Plan:
- Reset mid-stream: 3 loads queued, busy[5]=1, assert rst 1 cycle → RegWrite=0, ld_ready=1, rs1=5 gives rs1_busy=0, no later writes.
- ALU write: alu_valid, alu_rd=3, alu_data=0xDEADBEEF in cycle 0 → cycle 1 RegWrite=1, rd=3, WriteData=0xDEADBEEF; alu_rd=0 → RegWrite=0.
- Load latency and scoreboard: issue_rd=7 in cycle 0 → rs1=7 busy from cycle 1. ld_rd=7, ld_data=0x1234 in cycle 2 → write in cycle 4; rs1_busy=0 in cycle 5.
- Priority and full: alu_valid held with rd=1..N while 4 loads arrive → ld_ready=0 after 4th push. Drop alu_valid → loads written in arrival order, one per cycle, ld_ready=1 after first pop.
- Simultaneous events: push+pop at count=2 → count stays 2. Issue to x9 in the same cycle as the load write to x9 → busy[9] stays 1.
- WAW: busy[4]=1, ALU writes x4 → write occurs, err_waw=1 and stays 1 until rst.
